// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, functs,
// ALUOp codes, mux selects, FSM states and decoded instruction classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_NONE  = 6'b000000;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_LUI   = 3'b001;
    localparam logic [2:0] ALUOP_SLTI  = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;
    localparam logic [2:0] ALUOP_SLTIU = 3'b100;
    localparam logic [2:0] ALUOP_ANDI  = 3'b101;
    localparam logic [2:0] ALUOP_ORI   = 3'b110;
    localparam logic [2:0] ALUOP_XORI  = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] ALUB_RT        = 2'b00;
    localparam logic [1:0] ALUB_FOUR      = 2'b01;
    localparam logic [1:0] ALUB_IMM       = 2'b10;
    localparam logic [1:0] ALUB_IMM_SHIFT = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
        ST_I_WB      = 4'd11,
        ST_JR        = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_R,
        CLS_JR,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_IMM,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the MIPS control FSM (master) and the datapath (slave).
// Handshake: a memory access started by mem_read/mem_write completes in the
// cycle mem_ready is high; the FSM holds its state and request until then.
interface mips_multicycle_control_if;
    import mips_ctrl_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [5:0] alu_funct;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, alu_funct, instr_done, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, alu_funct, instr_done, illegal_op, state
    );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct classifier; also supplies the ALUOp used by
// I-type instructions in I_EXEC.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_JR = 1'b1
) (
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic [2:0]   imm_alu_op
);

    always_comb begin
        cls        = CLS_ILLEGAL;
        imm_alu_op = ALUOP_ADD;
        case (opcode)
            OP_LW, OP_SW:   cls = CLS_MEM;
            OP_RTYPE: begin
                if (funct == FN_JR) cls = ENABLE_JR ? CLS_JR : CLS_ILLEGAL;
                else                cls = CLS_R;
            end
            OP_BEQ, OP_BNE: cls = CLS_BRANCH;
            OP_J:           cls = CLS_JUMP;
            OP_ADDI:  begin cls = CLS_IMM; imm_alu_op = ALUOP_ADD;   end
            OP_SLTI:  begin cls = CLS_IMM; imm_alu_op = ALUOP_SLTI;  end
            OP_SLTIU: begin cls = CLS_IMM; imm_alu_op = ALUOP_SLTIU; end
            OP_ANDI:  begin cls = CLS_IMM; imm_alu_op = ALUOP_ANDI;  end
            OP_ORI:   begin cls = CLS_IMM; imm_alu_op = ALUOP_ORI;   end
            OP_XORI:  begin cls = CLS_IMM; imm_alu_op = ALUOP_XORI;  end
            OP_LUI:   begin cls = CLS_IMM; imm_alu_op = ALUOP_LUI;   end
            default:        cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and writeback; the current state is exported on bus.state.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter bit         ENABLE_JR   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_control_if.master  bus
);

    state_t       state_q, state_d;
    instr_class_t cls;
    logic [2:0]   imm_alu_op;

    mips_ctrl_decode #(.ENABLE_JR(ENABLE_JR)) u_decode (
        .opcode     (bus.opcode),
        .funct      (bus.funct),
        .cls        (cls),
        .imm_alu_op (imm_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    assign bus.state = state_q;

    always_comb begin
        state_d        = state_q;
        bus.pc_en      = 1'b0;
        bus.pc_source  = PCSRC_ALU;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = REGDST_RT;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ALUB_RT;
        bus.alu_op     = ALUOP_RTYPE;
        bus.alu_funct  = FN_NONE;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;

        case (state_q)
            ST_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = ALUB_FOUR;
                bus.alu_op    = ALUOP_ADD;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_en    = 1'b1;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                bus.alu_src_b = ALUB_IMM_SHIFT;
                bus.alu_op    = ALUOP_ADD;
                case (cls)
                    CLS_MEM:    state_d = ST_MEM_ADDR;
                    CLS_R:      state_d = ST_R_EXEC;
                    CLS_JR:     state_d = ST_JR;
                    CLS_BRANCH: state_d = ST_BRANCH;
                    CLS_JUMP:   state_d = ST_JUMP;
                    CLS_IMM:    state_d = ST_I_EXEC;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUB_IMM;
                bus.alu_op    = ALUOP_ADD;
                state_d       = (bus.opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_d        = ST_FETCH;
                end
            end
            ST_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_funct = bus.funct;
                state_d       = ST_R_WB;
            end
            ST_R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = REGDST_RD;
                bus.instr_done = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_funct  = FN_SUB;
                bus.pc_source  = PCSRC_ALUOUT;
                bus.pc_en      = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                bus.instr_done = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_JUMP: begin
                bus.pc_source  = PCSRC_JUMP;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUB_IMM;
                bus.alu_op    = imm_alu_op;
                state_d       = ST_I_WB;
            end
            ST_I_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_JR: begin
                bus.pc_source  = PCSRC_RS;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset must block every architectural write even though FETCH decodes.
        if (!rst_n) begin
            bus.pc_en      = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.mem_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class
// through its state sequence and checks the decoded control outputs.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;

  mips_multicycle_control_if bus0 ();
  mips_multicycle_control_if bus1 ();

  assign bus1.opcode    = bus0.opcode;
  assign bus1.funct     = bus0.funct;
  assign bus1.zero      = bus0.zero;
  assign bus1.mem_ready = bus0.mem_ready;

  mips_multicycle_control #(.RESET_STATE(4'd0), .ENABLE_JR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mips_multicycle_control #(.RESET_STATE(4'd0), .ENABLE_JR(1'b0)) dut_nojr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus0.instr_done === 1'b1) done_cnt++;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: FETCH (mem_ready=1) then DECODE; returns in the post-decode state
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn,
                              input logic ill0, input logic ill1, input string tag);
    bus0.opcode    = op;
    bus0.funct     = fn;
    bus0.mem_ready = 1'b1;
    #1;
    check_eq({tag, " fetch state"}, bus0.state, 32'd0);
    check_eq({tag, " fetch ir_write"}, bus0.ir_write, 32'd1);
    check_eq({tag, " fetch pc_en"}, bus0.pc_en, 32'd1);
    tick();
    check_eq({tag, " decode state"}, bus0.state, 32'd1);
    check_eq({tag, " decode alu_src_b"}, bus0.alu_src_b, 32'd3);
    check_eq({tag, " decode alu_op"}, bus0.alu_op, 32'd3);
    check_eq({tag, " decode illegal"}, bus0.illegal_op, ill0);
    check_eq({tag, " decode illegal nojr"}, bus1.illegal_op, ill1);
    check_eq({tag, " decode pc_en"}, bus0.pc_en, 32'd0);
    check_eq({tag, " decode reg_write"}, bus0.reg_write, 32'd0);
    tick();
  endtask

  logic [5:0] imm_ops [7];
  logic [2:0] imm_exp [7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    imm_ops = '{6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    imm_exp = '{3'b011, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
    rst_n          = 1'b0;
    bus0.opcode    = 6'd0;
    bus0.funct     = 6'd0;
    bus0.zero      = 1'b0;
    bus0.mem_ready = 1'b1;

    // reset state
    #3;
    check_eq("rst state", bus0.state, 32'd0);
    check_eq("rst pc_en", bus0.pc_en, 32'd0);
    check_eq("rst ir_write", bus0.ir_write, 32'd0);
    check_eq("rst mem_read", bus0.mem_read, 32'd1);
    check_eq("rst alu_src_b", bus0.alu_src_b, 32'd1);
    check_eq("rst alu_op", bus0.alu_op, 32'd3);
    check_eq("rst i_or_d", bus0.i_or_d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add: 0,1,6,7,0
    fetch_decode(6'b000000, 6'b100000, 1'b0, 1'b0, "add");
    check_eq("add rexec state", bus0.state, 32'd6);
    check_eq("add rexec alu_op", bus0.alu_op, 32'd0);
    check_eq("add rexec alu_funct", bus0.alu_funct, 32'h20);
    check_eq("add rexec src_a", bus0.alu_src_a, 32'd1);
    check_eq("add rexec src_b", bus0.alu_src_b, 32'd0);
    check_eq("add rexec reg_write", bus0.reg_write, 32'd0);
    tick();
    check_eq("add rwb state", bus0.state, 32'd7);
    check_eq("add rwb reg_write", bus0.reg_write, 32'd1);
    check_eq("add rwb reg_dst", bus0.reg_dst, 32'd1);
    check_eq("add rwb mem_to_reg", bus0.mem_to_reg, 32'd0);
    check_eq("add rwb done", bus0.instr_done, 32'd1);
    check_eq("add rwb alu_funct", bus0.alu_funct, 32'd0);
    tick();
    check_eq("add end state", bus0.state, 32'd0);
    check_eq("add done count", done_cnt, 32'd1);

    // lw with 3 wait cycles in MEM_READ
    fetch_decode(6'b100011, 6'd0, 1'b0, 1'b0, "lw");
    check_eq("lw addr state", bus0.state, 32'd2);
    check_eq("lw addr src_a", bus0.alu_src_a, 32'd1);
    check_eq("lw addr src_b", bus0.alu_src_b, 32'd2);
    check_eq("lw addr alu_op", bus0.alu_op, 32'd3);
    tick();
    bus0.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("lw read state", bus0.state, 32'd3);
      check_eq("lw read mem_read", bus0.mem_read, 32'd1);
      check_eq("lw read i_or_d", bus0.i_or_d, 32'd1);
      check_eq("lw read reg_write", bus0.reg_write, 32'd0);
      tick();
    end
    bus0.mem_ready = 1'b1;
    #1;
    check_eq("lw read last state", bus0.state, 32'd3);
    tick();
    check_eq("lw wb state", bus0.state, 32'd4);
    check_eq("lw wb reg_write", bus0.reg_write, 32'd1);
    check_eq("lw wb mem_to_reg", bus0.mem_to_reg, 32'd1);
    check_eq("lw wb reg_dst", bus0.reg_dst, 32'd0);
    check_eq("lw wb done", bus0.instr_done, 32'd1);
    tick();
    check_eq("lw end state", bus0.state, 32'd0);

    // beq taken, bne not taken (zero=1 for both)
    bus0.zero = 1'b1;
    fetch_decode(6'b000100, 6'd0, 1'b0, 1'b0, "beq");
    check_eq("beq state", bus0.state, 32'd8);
    check_eq("beq pc_en", bus0.pc_en, 32'd1);
    check_eq("beq pc_source", bus0.pc_source, 32'd1);
    check_eq("beq alu_op", bus0.alu_op, 32'd0);
    check_eq("beq alu_funct", bus0.alu_funct, 32'h22);
    check_eq("beq src_a", bus0.alu_src_a, 32'd1);
    check_eq("beq done", bus0.instr_done, 32'd1);
    tick();
    fetch_decode(6'b000101, 6'd0, 1'b0, 1'b0, "bne");
    check_eq("bne state", bus0.state, 32'd8);
    check_eq("bne pc_en", bus0.pc_en, 32'd0);
    check_eq("bne alu_funct", bus0.alu_funct, 32'h22);
    check_eq("bne done", bus0.instr_done, 32'd1);
    tick();
    bus0.zero = 1'b0;

    // j
    fetch_decode(6'b000010, 6'd0, 1'b0, 1'b0, "j");
    check_eq("j state", bus0.state, 32'd9);
    check_eq("j pc_en", bus0.pc_en, 32'd1);
    check_eq("j pc_source", bus0.pc_source, 32'd2);
    check_eq("j done", bus0.instr_done, 32'd1);
    tick();

    // jr: legal on dut, illegal on dut_nojr
    fetch_decode(6'b000000, 6'b001000, 1'b0, 1'b1, "jr");
    bus0.mem_ready = 1'b0;
    #1;
    check_eq("jr state", bus0.state, 32'd12);
    check_eq("jr pc_en", bus0.pc_en, 32'd1);
    check_eq("jr pc_source", bus0.pc_source, 32'd3);
    check_eq("jr done", bus0.instr_done, 32'd1);
    check_eq("nojr state", bus1.state, 32'd0);
    check_eq("nojr pc_en", bus1.pc_en, 32'd0);
    check_eq("nojr reg_write", bus1.reg_write, 32'd0);
    tick();
    check_eq("jr end state", bus0.state, 32'd0);
    check_eq("nojr end state", bus1.state, 32'd0);

    // I-type ALUOp table
    for (int k = 0; k < 7; k++) begin
      fetch_decode(imm_ops[k], 6'd0, 1'b0, 1'b0, "itype");
      check_eq("itype exec state", bus0.state, 32'd10);
      check_eq("itype alu_op", bus0.alu_op, imm_exp[k]);
      check_eq("itype src_b", bus0.alu_src_b, 32'd2);
      tick();
      check_eq("itype wb state", bus0.state, 32'd11);
      check_eq("itype wb reg_write", bus0.reg_write, 32'd1);
      check_eq("itype wb reg_dst", bus0.reg_dst, 32'd0);
      check_eq("itype wb done", bus0.instr_done, 32'd1);
      tick();
    end

    // unsupported opcode
    fetch_decode(6'b111111, 6'd0, 1'b1, 1'b1, "illegal");
    check_eq("illegal end state", bus0.state, 32'd0);

    // reset during MEM_WRITE aborts the store
    fetch_decode(6'b101011, 6'd0, 1'b0, 1'b0, "sw");
    check_eq("sw addr state", bus0.state, 32'd2);
    tick();
    bus0.mem_ready = 1'b0;
    #1;
    check_eq("sw write state", bus0.state, 32'd5);
    check_eq("sw write mem_write", bus0.mem_write, 32'd1);
    check_eq("sw write done", bus0.instr_done, 32'd0);
    tick();
    check_eq("sw hold state", bus0.state, 32'd5);
    bus0.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("abort mem_write", bus0.mem_write, 32'd0);
    check_eq("abort state", bus0.state, 32'd0);
    check_eq("abort done", bus0.instr_done, 32'd0);
    check_eq("abort ir_write", bus0.ir_write, 32'd0);
    check_eq("abort pc_en", bus0.pc_en, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("release ir_write", bus0.ir_write, 32'd1);
    check_eq("release state", bus0.state, 32'd0);
    tick();
    check_eq("release decode state", bus0.state, 32'd1);

    // add, lw, beq, bne, j, jr, 7 I-types retire; illegal and aborted sw do not
    check_eq("total retired", done_cnt, 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS core. It sequences fetch, decode, execute, memory and writeback over a shared ALU, register file and a single memory port. Each cycle it drives the 3-bit ALUOp and a 6-bit ALU function into the ALU control unit. It stalls on a memory ready handshake, resolves branches and jumps, and flags unsupported opcodes.

Parameters:
RESET_STATE, 4'd0, encoded state entered on reset (FETCH)
ENABLE_JR, 1, 1 = R-type funct 001000 executes as jr; 0 = treated as illegal

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, same cycle
mem_ready  input  1  memory completes the current access this cycle
pc_en  output  1  PC register load enable
pc_source  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (jr)
i_or_d  output  1  0 = address from PC, 1 = address from ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load enable
reg_dst  output  2  00 rt, 01 rd
mem_to_reg  output  1  0 = ALUOut, 1 = MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
alu_op  output  3  ALUOp to ALU control
alu_funct  output  6  function field to ALU control
instr_done  output  1  1-cycle pulse when an instruction retires
illegal_op  output  1  1-cycle pulse in DECODE on an unsupported opcode or funct
state  output  4  current state, for debug

Behaviour:
- ALUOp encoding: 000 R-type (function decoded), 001 lui, 010 slti, 011 add (addi/address), 100 sltiu, 101 andi, 110 ori, 111 xori.
- alu_funct equals the funct input in R_EXEC. In BRANCH it is forced to 100010 (sub) with alu_op 000. In all other states it is 000000.
- Reset: state = FETCH. While rst_n is low, pc_en, ir_write, reg_write, mem_write, instr_done and illegal_op are forced to 0. All other outputs are decoded from FETCH.
- States and transitions:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=011, pc_source=00. When mem_ready=1: ir_write=1, pc_en=1, go to DECODE. Otherwise hold FETCH with ir_write=0 and pc_en=0.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=011 (branch target into ALUOut). Next state by opcode:
    - lw/sw (100011/101011) -> MEM_ADDR
    - R-type (000000) -> R_EXEC, or JR if funct=001000 and ENABLE_JR=1
    - beq/bne (000100/000101) -> BRANCH
    - j (000010) -> JUMP
    - addi/slti/sltiu/andi/ori/xori/lui (001000, 001010, 001011, 001100, 001101, 001110, 001111) -> I_EXEC
    - anything else, or R-type funct=001000 with ENABLE_JR=0 -> illegal_op=1, return to FETCH
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=011. Go to MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ(3): mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
  - MEM_WB(4): reg_write=1, reg_dst=00, mem_to_reg=1, instr_done=1 -> FETCH.
  - MEM_WRITE(5): mem_write=1, i_or_d=1. Hold until mem_ready. On that cycle instr_done=1 -> FETCH.
  - R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=000 -> R_WB.
  - R_WB(7): reg_write=1, reg_dst=01, mem_to_reg=0, instr_done=1 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, pc_source=01. pc_en = zero for beq, ~zero for bne. instr_done=1 -> FETCH.
  - JUMP(9): pc_source=10, pc_en=1, instr_done=1 -> FETCH.
  - I_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op per opcode (lui 001, slti 010, addi 011, sltiu 100, andi 101, ori 110, xori 111) -> I_WB.
  - I_WB(11): reg_write=1, reg_dst=00, mem_to_reg=0, instr_done=1 -> FETCH.
  - JR(12): pc_source=11, pc_en=1, instr_done=1 -> FETCH.
- Undefined state encodings go to FETCH on the next clock.
- Every outputs not listed for a state is 0.
- Latency per instruction, with mem_ready=1 on the first cycle of each access:
  - lw: 5 cycles
  - R-type, I-type, sw: 4 cycles
  - beq/bne, j, jr: 3 cycles
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- An rst_n assertion mid-instruction aborts it immediately; no further writes occur.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - the ALUOp encodings above
  - the state enum
  - pc_source and alu_src_b encodings
- Sub-module mips_ctrl_decode is combinational. It maps opcode/funct to an instruction class (MEM, R, JR, BRANCH, JUMP, IMM, ILLEGAL) plus the I-type ALUOp. The FSM instantiates it.

Test Plan:
- add (opcode 000000, funct 100000), mem_ready=1 -> states 0,1,6,7,0; alu_op=000 and alu_funct=100000 in R_EXEC; reg_write and reg_dst=01 in R_WB; instr_done once.
- lw with mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles; no reg_write until MEM_WB; mem_to_reg=1 there.
- beq with zero=1, then bne with zero=1 -> pc_en=1 with pc_source=01 for beq; pc_en=0 for bne; alu_op=000 and alu_funct=100010 in BRANCH.
- Each I-type opcode 001000..001111 (excluding 001001) -> alu_op in I_EXEC = 011, 010, 100, 101, 110, 111, 001 respectively.
- opcode 111111, and jr with ENABLE_JR=0 -> illegal_op pulse in DECODE, return to FETCH, no reg_write or pc_en.
- rst_n driven low during MEM_WRITE with mem_ready=1 -> mem_write=0 immediately; state=FETCH; after release, first fetch begins on the next edge.
